// File: rtl/laser_pkg.sv
// Shared definitions for the laser point feeder: default frame size,
// FSM state encoding and the packed {y,x} point type.
package laser_pkg;

  localparam int OBJ_NUM_DEF = 40;
  localparam int CNT_W_DEF   = 6;

  typedef enum logic [1:0] {
    ST_FILL      = 2'd0,
    ST_STREAM    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } feed_state_t;

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] x;
  } pt_t;

  function automatic pt_t mk_pt(input logic [3:0] x, input logic [3:0] y);
    pt_t p;
    p.x = x;
    p.y = y;
    return p;
  endfunction

endpackage

// File: rtl/laser_pt_buf.sv
// Point buffer: OBJ_NUM x 8 register file, synchronous write, combinational read.
// match[i] flags entries below cmp_cnt equal to cmp_dat (zero when cmp_cnt is 0).
module laser_pt_buf
  import laser_pkg::*;
#(
  parameter int OBJ_NUM = OBJ_NUM_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               CLK,
  input  logic               wr_vld,
  input  logic [CNT_W-1:0]   wr_addr,
  input  pt_t                wr_dat,
  input  logic [CNT_W-1:0]   rd_addr,
  output pt_t                rd_dat,
  input  pt_t                cmp_dat,
  input  logic [CNT_W-1:0]   cmp_cnt,
  output logic [OBJ_NUM-1:0] match
);

  // Contents are never reset: every entry is rewritten before it is read.
  pt_t mem [OBJ_NUM];

  always_ff @(posedge CLK) begin
    if (wr_vld) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

  always_comb begin
    match = '0;
    for (int i = 0; i < OBJ_NUM; i++) begin
      match[i] = (CNT_W'(i) < cmp_cnt) && (mem[i] == cmp_dat);
    end
  end

endmodule

// File: rtl/laser_feeder.sv
// Collects OBJ_NUM points (IN_READY drops once full), then streams them one per cycle with no backpressure,
// first point in the cycle after the last accept. Optional duplicate filtering with LASER_FEEDER_DEDUP_EN.
module laser_feeder
  import laser_pkg::*;
#(
  parameter int OBJ_NUM = OBJ_NUM_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       IN_VALID,
  input  logic [3:0] IN_X,
  input  logic [3:0] IN_Y,
  output logic       IN_READY,
  output logic [3:0] X,
  output logic [3:0] Y,
  output logic       OUT_VALID,
  input  logic       DONE,
  output logic [7:0] FRAME_CNT
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(OBJ_NUM - 1);

  feed_state_t        state;
  logic [CNT_W-1:0]   wr_cnt;
  logic [CNT_W-1:0]   rd_cnt;
  logic [CNT_W-1:0]   rd_addr;
  logic [CNT_W-1:0]   cmp_cnt;
  pt_t                in_dat;
  pt_t                rd_dat;
  pt_t                first_pt;
  logic [OBJ_NUM-1:0] match;
  logic               dup;
  logic               wr_fire;
  logic               last_fire;
  logic               last_out;

  assign in_dat = mk_pt(IN_X, IN_Y);

`ifdef LASER_FEEDER_DEDUP_EN
  assign cmp_cnt = wr_cnt;
`else
  // A zero compare window keeps match all-zero, so every point is stored.
  assign cmp_cnt = '0;
`endif

  assign dup       = |match;
  assign wr_fire   = IN_VALID && IN_READY && !dup;
  assign last_fire = wr_fire && (wr_cnt == LAST);
  assign last_out  = (rd_cnt == LAST);

  // rd_cnt indexes the point on X/Y now; the buffer is read one ahead.
  assign rd_addr  = (state == ST_STREAM && !last_out) ? rd_cnt + 1'b1 : '0;
  assign first_pt = (wr_cnt == '0) ? in_dat : rd_dat;

  laser_pt_buf #(
    .OBJ_NUM (OBJ_NUM),
    .CNT_W   (CNT_W)
  ) u_buf (
    .CLK     (CLK),
    .wr_vld  (wr_fire),
    .wr_addr (wr_cnt),
    .wr_dat  (in_dat),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat),
    .cmp_dat (in_dat),
    .cmp_cnt (cmp_cnt),
    .match   (match)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_FILL;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
      X         <= '0;
      Y         <= '0;
      FRAME_CNT <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (wr_fire) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (last_fire) begin
              state     <= ST_STREAM;
              IN_READY  <= 1'b0;
              OUT_VALID <= 1'b1;
              {Y, X}    <= first_pt;
              rd_cnt    <= '0;
            end
          end
        end
        ST_STREAM: begin
          if (last_out) begin
            state     <= ST_WAIT_DONE;
            OUT_VALID <= 1'b0;
            X         <= '0;
            Y         <= '0;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
            {Y, X} <= rd_dat;
          end
        end
        ST_WAIT_DONE: begin
          if (DONE) begin
            state     <= ST_FILL;
            IN_READY  <= 1'b1;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            FRAME_CNT <= FRAME_CNT + 1'b1;
          end
        end
        default: begin
          state     <= ST_FILL;
          IN_READY  <= 1'b1;
          OUT_VALID <= 1'b0;
          X         <= '0;
          Y         <= '0;
          wr_cnt    <= '0;
          rd_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/laser_feeder.md
LASER_FEEDER -- requirements
Module: laser_feeder

Interface
REQ-001 SHALL have parameter OBJ_NUM, default 40, giving the object points per frame.
REQ-002 SHALL have parameter CNT_W, default 6, giving the point-counter width (2^CNT_W >= OBJ_NUM).
REQ-003 SHALL have port CLK  input  1  as the single clock; all flops on rising edge.
REQ-004 SHALL have port RST_N  input  1  as the reset: asynchronous, active-low.
REQ-005 SHALL have port IN_VALID  input  1  to mark the upstream point as valid.
REQ-006 SHALL have port IN_X  input  4  as the upstream point X coordinate.
REQ-007 SHALL have port IN_Y  input  4  as the upstream point Y coordinate.
REQ-008 SHALL have port IN_READY  output  1  to signal that the feeder accepts a point.
REQ-009 SHALL have port X  output  4  as the streamed point X to the laser solver.
REQ-010 SHALL have port Y  output  4  as the streamed point Y to the laser solver.
REQ-011 SHALL have port OUT_VALID  output  1  to mark X/Y as valid this cycle.
REQ-012 SHALL have port DONE  input  1  as the solver done pulse that ends the frame.
REQ-013 SHALL have port FRAME_CNT  output  8  counting completed frames.

Function
REQ-014 SHALL implement states FILL, STREAM, WAIT_DONE.
REQ-015 SHALL, in FILL, drive IN_READY=1 and store {IN_Y,IN_X} into buffer[wr_cnt] and increment wr_cnt on each cycle with IN_VALID&&IN_READY.
REQ-016 SHALL go FILL->STREAM on the cycle the OBJ_NUM-th point is accepted; IN_READY is 0 from the next cycle.
REQ-017 SHALL, in STREAM, hold OUT_VALID=1 for exactly OBJ_NUM consecutive cycles, with X/Y = buffer[0..OBJ_NUM-1] in arrival order, one point per cycle, with no gaps and no backpressure.
REQ-018 SHALL drive X/Y from a register (first point visible in the first STREAM cycle) and drive X=Y=0 whenever OUT_VALID=0.
REQ-019 SHALL go STREAM->WAIT_DONE after the last point cycle, then WAIT_DONE->FILL on DONE=1, clearing wr_cnt and rd_cnt.
REQ-020 SHALL increment FRAME_CNT by 1 on each WAIT_DONE->FILL transition, wrapping 255->0.
REQ-021 SHALL ignore DONE in FILL and STREAM (no state change, no count).
REQ-022 SHALL ignore IN_VALID while IN_READY=0 (no write, no counter change).

Reset
REQ-023 SHALL, on RST_N low, immediately set state=FILL, wr_cnt=rd_cnt=0, IN_READY=1 after release, OUT_VALID=0, X=Y=0, FRAME_CNT=0.
REQ-024 SHALL leave buffer contents unreset; they are not observable before being rewritten.
REQ-025 SHALL drop any partially filled or partially streamed frame on reset mid-operation and restart at FILL.

Configuration
REQ-026 SHALL, with macro LASER_FEEDER_DEDUP_EN defined, compare an accepted point against buffer[0..wr_cnt-1] and discard it when it is a duplicate (no write, wr_cnt unchanged, IN_READY stays 1).
REQ-027 SHALL, without LASER_FEEDER_DEDUP_EN, store every accepted point, including duplicates.

Structure
REQ-028 SHALL place OBJ_NUM default, state encoding, and the packed point type {y[3:0],x[3:0]} in shared package laser_pkg.
REQ-029 SHALL use a single sub-module, laser_pt_buf (OBJ_NUM x 8 register file, one write port, one read port, plus a match vector for dedup); all other logic is inline.

Verification
REQ-030 SHALL cover: 40 back-to-back points (i,i%16) -> OUT_VALID high for 40 cycles, X/Y in order, then WAIT_DONE.
REQ-031 SHALL cover: IN_VALID toggled every other cycle -> 40 points stored, STREAM entered on the 40th accept.
REQ-032 SHALL cover: DONE pulsed during STREAM -> ignored; DONE pulsed in WAIT_DONE -> FILL, FRAME_CNT 0->1.
REQ-033 SHALL cover: RST_N low at point 20 of STREAM -> OUT_VALID=0, X=Y=0, FILL, FRAME_CNT=0.
REQ-034 SHALL cover, with DEDUP_EN: point (3,5) sent 3 times among 42 inputs -> 40 unique points streamed; without DEDUP_EN: first 40 inputs streamed.
REQ-035 SHALL cover: 256 full frames -> FRAME_CNT wraps to 0.
